io_mmio_ctrl: RTL and testbench

// - Memory-mapped I/O peripheral between the single-cycle MIPS data bus and the 7-segment display driver.
// - Synchronizes and debounces 16 board switches and 5 push buttons; debounced switches drive the display's switch input.
// - Holds a CPU-writable 12-bit LED/display register that feeds the display's led input.
// - Latches sticky button-press flags the CPU can poll, or take as an interrupt.

---
 rtl/io_mmio_ctrl.sv | 134 +++++++++++++
 tb/tb_io_mmio_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_mmio_ctrl.sv
// MMIO peripheral: debounced switches/buttons, LED register and sticky button flags for the CPU.
// Optional button interrupt (CTRL register and irq) is built when IO_BTN_IRQ_EN is defined.
module io_mmio_ctrl #(
    parameter int unsigned DB_LIMIT = 1_000_000,
    parameter int unsigned DB_CNT_W = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sw_raw,
    input  logic [4:0]  btn_raw,
    input  logic [3:0]  cpu_addr,
    input  logic        cpu_we,
    input  logic        cpu_re,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic [15:0] switch,
    output logic [11:0] led,
    output logic        irq
);

    localparam int unsigned NumIn = 21;
    localparam logic [DB_CNT_W-1:0] CntMax = DB_CNT_W'(DB_LIMIT - 1);

    localparam logic [1:0] RegSw   = 2'd0;
    localparam logic [1:0] RegLed  = 2'd1;
    localparam logic [1:0] RegBtn  = 2'd2;
    localparam logic [1:0] RegCtrl = 2'd3;

    logic [NumIn-1:0]    raw;
    logic [NumIn-1:0]    sync1_q, sync2_q;
    logic [NumIn-1:0]    smp_q, smp_d;
    logic [NumIn-1:0]    db_q, db_d;
    logic [NumIn-1:0]    stable;
    logic [DB_CNT_W-1:0] cnt_q, cnt_d;
    logic                tick;
    logic [4:0]          btn_prev_q;
    logic [4:0]          btn_rise, btn_clr;
    logic [4:0]          btn_flags_q, btn_flags_d;
    logic [11:0]         led_q, led_d;
    logic                irq_en;
    logic                irq_q, irq_d;
    logic [1:0]          reg_sel;
    logic                unused_bits;

    assign reg_sel     = cpu_addr[3:2];
    assign unused_bits = ^{cpu_addr[1:0], cpu_wdata[31:12]};

`ifdef IO_BTN_IRQ_EN
    logic irq_en_q, irq_en_d;

    always_comb begin
        irq_en_d = irq_en_q;
        if (cpu_we && reg_sel == RegCtrl) begin
            irq_en_d = cpu_wdata[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en_q <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
        end
    end

    assign irq_en = irq_en_q;
    assign irq_d  = irq_en_d & (|btn_flags_d);
`else
    assign irq_en = 1'b0;
    assign irq_d  = 1'b0;
`endif

    always_comb begin
        raw    = {btn_raw, sw_raw};
        tick   = (cnt_q == CntMax);
        cnt_d  = tick ? '0 : cnt_q + 1'b1;
        smp_d  = tick ? sync2_q : smp_q;
        // A bit only follows the input once two consecutive samples agree.
        stable = ~(sync2_q ^ smp_q);
        db_d   = tick ? ((stable & sync2_q) | (~stable & db_q)) : db_q;

        btn_rise    = db_q[20:16] & ~btn_prev_q;
        btn_clr     = (cpu_we && reg_sel == RegBtn) ? cpu_wdata[4:0] : 5'b0;
        // A new press outranks a same-cycle W1C so no press is lost.
        btn_flags_d = (btn_flags_q & ~btn_clr) | btn_rise;

        led_d = led_q;
        if (cpu_we && reg_sel == RegLed) begin
            led_d = cpu_wdata[11:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            cnt_q       <= '0;
            smp_q       <= '0;
            db_q        <= '0;
            btn_prev_q  <= '0;
            btn_flags_q <= '0;
            led_q       <= '0;
            irq_q       <= 1'b0;
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            cnt_q       <= cnt_d;
            smp_q       <= smp_d;
            db_q        <= db_d;
            btn_prev_q  <= db_q[20:16];
            btn_flags_q <= btn_flags_d;
            led_q       <= led_d;
            irq_q       <= irq_d;
        end
    end

    always_comb begin
        cpu_rdata = 32'h0;
        if (cpu_re) begin
            case (reg_sel)
                RegSw:   cpu_rdata = {16'b0, db_q[15:0]};
                RegLed:  cpu_rdata = {20'b0, led_q};
                RegBtn:  cpu_rdata = {27'b0, btn_flags_q};
                RegCtrl: cpu_rdata = {31'b0, irq_en};
                default: cpu_rdata = 32'h0;
            endcase
        end
    end

    assign switch = db_q[15:0];
    assign led    = led_q;
    assign irq    = irq_q;

endmodule

// File: tb/tb_io_mmio_ctrl.sv
// Self-checking bench for io_mmio_ctrl with DB_LIMIT=4; define IO_BTN_IRQ_EN for both files
// to exercise the interrupt build.
module tb_io_mmio_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] sw_raw = 16'h0;
    logic [4:0]  btn_raw = 5'h0;
    logic [3:0]  cpu_addr = 4'h0;
    logic        cpu_we = 1'b0;
    logic        cpu_re = 1'b0;
    logic [31:0] cpu_wdata = 32'h0;
    logic [31:0] cpu_rdata;
    logic [15:0] switch;
    logic [11:0] led;
    logic        irq;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;
    logic [31:0] got;

    io_mmio_ctrl #(
        .DB_LIMIT(4),
        .DB_CNT_W(3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sw_raw   (sw_raw),
        .btn_raw  (btn_raw),
        .cpu_addr (cpu_addr),
        .cpu_we   (cpu_we),
        .cpu_re   (cpu_re),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .switch   (switch),
        .led      (led),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // Posedges since reset release; debounce samples land on multiples of 4.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        cpu_we    = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
        @(negedge clk);
        cpu_we    = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a);
        cpu_re   = 1'b1;
        cpu_addr = a;
        #1;
        got      = cpu_rdata;
        cpu_re   = 1'b0;
    endtask

    task automatic test_reset;
        sw_raw = 16'hA5C3;
        repeat (3) @(negedge clk);
        exp_q.push_back(32'h0);
        #1;
        exp_v = exp_q.pop_front();
        n_cmp++;
        if ({16'h0, switch} !== exp_v) begin
            n_err++; $display("FAIL reset_switch: got %h required %h", switch, exp_v);
        end
        exp_q.push_back(32'h0);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if ({19'h0, irq, led} !== exp_v) begin
            n_err++; $display("FAIL reset_led_irq: got led=%h irq=%b required 0", led, irq);
        end
        exp_q.push_back(32'h0);
        bus_read(4'h0);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (got !== exp_v) begin
            n_err++; $display("FAIL reset_rdata: got %h required %h", got, exp_v);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        exp_q.push_back(32'h0);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if ({16'h0, switch} !== exp_v) begin
            n_err++; $display("FAIL release_switch: got %h required %h", switch, exp_v);
        end
        exp_q.push_back(32'h0000A5C3);
        for (int i = 0; i < 11 && switch !== 16'hA5C3; i++) @(negedge clk);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if ({16'h0, switch} !== exp_v) begin
            n_err++; $display("FAIL switch_settle: got %h required %h", switch, exp_v);
        end
        exp_q.push_back(32'h0000A5C3);
        bus_read(4'h0);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (got !== exp_v) begin
            n_err++; $display("FAIL sw_read: got %h required %h", got, exp_v);
        end
    endtask

    task automatic test_bounce;
        // Phase chosen so no two consecutive samples catch the bouncing level low.
        while (cyc % 2 != 0) @(negedge clk);
        for (int t = 0; t < 58; t++) begin
            if (t < 42 && t % 3 == 0) sw_raw[0] = ~sw_raw[0];
            exp_q.push_back(32'h1);
            #1;
            exp_v = exp_q.pop_front();
            n_cmp++;
            if ({31'h0, switch[0]} !== exp_v) begin
                n_err++; $display("FAIL bounce_t%0d: got %b required %b", t, switch[0], exp_v[0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_led;
        exp_q.push_back(32'h123);
        bus_write(4'h4, 32'hFFFF_F123);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if ({20'h0, led} !== exp_v) begin
            n_err++; $display("FAIL led_out: got %h required %h", led, exp_v);
        end
        exp_q.push_back(32'h0000_0123);
        bus_read(4'h4);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (got !== exp_v) begin
            n_err++; $display("FAIL led_read: got %h required %h", got, exp_v);
        end
        // Read and write together: old value read, new value committed.
        @(negedge clk);
        exp_q.push_back(32'h0000_0123);
        exp_q.push_back(32'h0000_0ABC);
        cpu_we = 1'b1; cpu_re = 1'b1; cpu_addr = 4'h4; cpu_wdata = 32'h0000_0ABC;
        #1;
        got = cpu_rdata;
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (got !== exp_v) begin
            n_err++; $display("FAIL rw_old: got %h required %h", got, exp_v);
        end
        @(negedge clk);
        cpu_we = 1'b0; cpu_re = 1'b0;
        exp_v = exp_q.pop_front();
        n_cmp++;
        if ({20'h0, led} !== exp_v) begin
            n_err++; $display("FAIL rw_new: got %h required %h", led, exp_v);
        end
        exp_q.push_back(32'h0000A5C3);
        bus_write(4'h0, 32'h0000_1111);
        bus_read(4'h0);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (got !== exp_v) begin
            n_err++; $display("FAIL sw_ro: got %h required %h", got, exp_v);
        end
    endtask

    task automatic test_btn;
        @(negedge clk);
        btn_raw[2] = 1'b1;
        repeat (12) @(negedge clk);
        btn_raw[2] = 1'b0;
        repeat (12) @(negedge clk);
        exp_q.push_back(32'h4);
        bus_read(4'h8);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (got !== exp_v) begin
            n_err++; $display("FAIL btn_flag: got %h required %h", got, exp_v);
        end
        exp_q.push_back(32'h0);
        bus_write(4'h8, 32'h4);
        bus_read(4'h8);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (got !== exp_v) begin
            n_err++; $display("FAIL btn_w1c: got %h required %h", got, exp_v);
        end
    endtask

    task automatic test_back_to_back;
        // Press starting at cyc=4j debounces at edge 4j+8; its rise sets the flag at 4j+9.
        while (cyc % 4 != 0) @(negedge clk);
        btn_raw[2] = 1'b1;
        repeat (8) @(negedge clk);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        cpu_we = 1'b1; cpu_re = 1'b1; cpu_addr = 4'h8; cpu_wdata = 32'h4;
        #1;
        got = cpu_rdata;
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (got !== exp_v) begin
            n_err++; $display("FAIL coincide_before: got %h required %h", got, exp_v);
        end
        @(negedge clk);
        cpu_we = 1'b0; cpu_re = 1'b0;
        bus_read(4'h8);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (got !== exp_v) begin
            n_err++; $display("FAIL coincide_set_wins: got %h required %h", got, exp_v);
        end
        btn_raw[2] = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_irq;
`ifdef IO_BTN_IRQ_EN
        exp_q.push_back(32'h0);
        #1;
        exp_v = exp_q.pop_front();
        n_cmp++;
        if ({31'h0, irq} !== exp_v) begin
            n_err++; $display("FAIL irq_masked: got %b required %b", irq, exp_v[0]);
        end
        @(negedge clk);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h1);
`else
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
`endif
        bus_write(4'hC, 32'h1);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if ({31'h0, irq} !== exp_v) begin
            n_err++; $display("FAIL irq_after_ctrl: got %b required %b", irq, exp_v[0]);
        end
        bus_read(4'hC);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (got !== exp_v) begin
            n_err++; $display("FAIL ctrl_read: got %h required %h", got, exp_v);
        end
        @(negedge clk);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        bus_write(4'h8, 32'h4);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if ({31'h0, irq} !== exp_v) begin
            n_err++; $display("FAIL irq_after_w1c: got %b required %b", irq, exp_v[0]);
        end
        bus_read(4'h8);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (got !== exp_v) begin
            n_err++; $display("FAIL btn_cleared: got %h required %h", got, exp_v);
        end
    endtask

    task automatic test_read_disable;
        for (int a = 0; a < 4; a++) begin
            @(negedge clk);
            exp_q.push_back(32'h0);
            cpu_re   = 1'b0;
            cpu_addr = 4'(a * 4);
            #1;
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (cpu_rdata !== exp_v) begin
                n_err++; $display("FAIL re_low_%0d: got %h required %h", a, cpu_rdata, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_write;
        @(negedge clk);
        reset = 1'b1;
        cpu_we = 1'b1; cpu_addr = 4'h4; cpu_wdata = 32'h0000_0555;
        @(negedge clk);
        reset = 1'b0;
        cpu_we = 1'b0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        #1;
        exp_v = exp_q.pop_front();
        n_cmp++;
        if ({20'h0, led} !== exp_v) begin
            n_err++; $display("FAIL reset_drops_write: got %h required %h", led, exp_v);
        end
        exp_v = exp_q.pop_front();
        n_cmp++;
        if ({16'h0, switch} !== exp_v) begin
            n_err++; $display("FAIL reset_clears_switch: got %h required %h", switch, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_led();
        test_btn();
        test_back_to_back();
        test_irq();
        test_read_disable();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
